// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM and its clear engine.
//   clr_state_e : clear-engine FSM state encoding
//   DEF_DATA_W  : default data word width
//   DEF_ADDR_W  : default address width
package ram_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear engine for ram_mem_dp: FSM, clear counter and the write-port mux into the array.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (restarts the clear from word 0)
//   clr       : clear request, honoured only in IDLE
//   we, waddr, wdata : user write request
//   busy      : registered, high while the array is being cleared
//   arr_we, arr_waddr, arr_wdata : write port actually applied to the array
//                                  (arr_waddr is the clear address while busy)
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              arr_we,
  output logic [ADDR_W-1:0] arr_waddr,
  output logic [DATA_W-1:0] arr_wdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state;
  logic [ADDR_W-1:0] cnt;
  logic              wr_in_range;

  // Exit on the last word rather than on wrap, so DEPTH == 2**ADDR_W never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEARING;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEARING;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEARING: begin
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign wr_in_range = int'(waddr) < DEPTH;

  // CLR wins over a same-edge user write; out-of-range writes vanish.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = waddr;
    arr_wdata = wdata;
    if (busy) begin
      arr_we    = 1'b1;
      arr_waddr = cnt;
      arr_wdata = '0;
    end else begin
      arr_we = we & ~clr & wr_in_range;
    end
  end

endmodule

// File: rtl/ram_mem_dp.sv
// Simple dual-port synchronous RAM with registered read, valid strobe,
// optional read-during-write bypass and a hardware clear engine.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset (starts a full clear)
//   WE, WADDR, DATA_IN: write port
//   RE, RADDR         : read port, result one cycle later
//   CLR               : clear request
//   DATA_OUT          : registered read data, holds when no read
//   DATA_VALID        : one-cycle strobe marking a fresh DATA_OUT
//   BUSY              : clear in progress; WE, RE and CLR are ignored
module ram_mem_dp
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 16,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RADDR,
  input  logic              CLR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  output logic              BUSY
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              rd_en;
  logic              rd_in_range;
  logic              bypass_hit;
  logic [DATA_W-1:0] rd_data;

  ram_clr_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_ctrl (
    .clk       (CLK),
    .rst       (RST),
    .clr       (CLR),
    .we        (WE),
    .waddr     (WADDR),
    .wdata     (DATA_IN),
    .busy      (BUSY),
    .arr_we    (arr_we),
    .arr_waddr (arr_waddr),
    .arr_wdata (arr_wdata)
  );

  // No write lands on an edge seen while reset is held.
  always_ff @(posedge CLK) begin
    if (arr_we && !RST) begin
      mem[arr_waddr] <= arr_wdata;
    end
  end

  assign rd_en       = RE & ~BUSY;
  assign rd_in_range = int'(RADDR) < DEPTH;
  // arr_we outside BUSY is exactly the user write that will commit this edge.
  assign bypass_hit  = (BYPASS != 0) && arr_we && !BUSY && (arr_waddr == RADDR);

  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = bypass_hit ? DATA_IN : mem[RADDR];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= rd_en;
      if (rd_en) begin
        DATA_OUT <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_mem_dp.sv
// Self-checking bench: two instances (DEPTH 16 / bypass, DEPTH 12 / no bypass) share stimulus
// and are compared each cycle against a per-instance behavioural model.
module tb_ram_mem_dp;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, re, clr;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b, busy_a, busy_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ram_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .BYPASS(1)) dut_a (
    .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DATA_IN(din), .RE(re), .RADDR(raddr),
    .CLR(clr), .DATA_OUT(dout_a), .DATA_VALID(valid_a), .BUSY(busy_a)
  );

  ram_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .BYPASS(0)) dut_b (
    .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .DATA_IN(din), .RE(re), .RADDR(raddr),
    .CLR(clr), .DATA_OUT(dout_b), .DATA_VALID(valid_b), .BUSY(busy_b)
  );

  // Behavioural model: a clear is "DEPTH cycles of unavailability, then all zeros".
  int            m_depth [2] = '{16, 12};
  bit            m_byp   [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m_mem   [2][16];
  int            m_busy  [2];
  logic [DW-1:0] m_dout  [2];
  bit            m_valid [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = m_depth[d];
      m_dout[d]  = '0;
      m_valid[d] = 1'b0;
      for (int w = 0; w < 16; w++) m_mem[d][w] = '0;
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d] > 0) begin
        m_busy[d]--;
        m_valid[d] = 1'b0;
      end else begin
        m_valid[d] = re;
        if (re) begin
          if (int'(raddr) >= m_depth[d]) m_dout[d] = '0;
          else if (m_byp[d] && we && !clr && waddr == raddr) m_dout[d] = din;
          else m_dout[d] = m_mem[d][raddr];
        end
        if (we && !clr && int'(waddr) < m_depth[d]) m_mem[d][waddr] = din;
        if (clr) begin
          m_busy[d] = m_depth[d];
          for (int w = 0; w < 16; w++) m_mem[d][w] = '0;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("busy_a",  32'(busy_a),  32'(m_busy[0] > 0));
    check("valid_a", 32'(valid_a), 32'(m_valid[0]));
    check("dout_a",  32'(dout_a),  32'(m_dout[0]));
    check("busy_b",  32'(busy_b),  32'(m_busy[1] > 0));
    check("valid_b", 32'(valid_b), 32'(m_valid[1]));
    check("dout_b",  32'(dout_b),  32'(m_dout[1]));
  endtask

  // Inputs are always changed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input int a, input int v);
    we = 1'b1; waddr = AW'(a); din = DW'(v);
    step();
    we = 1'b0;
  endtask

  task automatic rd(input int a);
    re = 1'b1; raddr = AW'(a);
    step();
    re = 1'b0;
  endtask

  // Counts cycles until BUSY of the 16-deep instance drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 40) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0;
    waddr = '0; raddr = '0; din = '0;
    model_reset();
    #2;
    check("rst_busy", 32'(busy_a), 32'd1);
    step();
    step();

    // Power-up clear: exactly DEPTH cycles, then everything reads zero.
    rst = 1'b0;
    count_busy(n);
    check("clr_len_rst", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) rd(a);

    // Consecutive writes then back-to-back reads.
    wr(10, 8'h2B);
    wr(11, 8'hDA);
    rd(10);
    check("rd_0a", 32'(dout_a), 32'h2B);
    rd(11);
    check("rd_0b", 32'(dout_a), 32'hDA);
    check("rd_0b_v", 32'(valid_a), 32'd1);
    step();
    check("valid_drop", 32'(valid_a), 32'd0);

    // Read-during-write to the same address.
    wr(3, 8'h11);
    we = 1'b1; waddr = 4'h3; din = 8'h55; re = 1'b1; raddr = 4'h3;
    step();
    we = 1'b0; re = 1'b0;
    check("bypass_new", 32'(dout_a), 32'h55);
    check("bypass_old", 32'(dout_b), 32'h11);
    rd(3);
    check("after_byp_b", 32'(dout_b), 32'h55);

    // Out-of-range address on the 12-deep instance.
    wr(13, 8'h77);
    rd(13);
    check("oor_dout_b", 32'(dout_b), 32'h00);
    check("oor_valid_b", 32'(valid_b), 32'd1);
    check("inr_dout_a", 32'(dout_a), 32'h77);
    for (int a = 0; a < 12; a++) rd(a);

    // Clear request beats a same-edge write; traffic during BUSY is ignored.
    for (int a = 0; a < 16; a++) wr(a, 8'hFF);
    clr = 1'b1; we = 1'b1; waddr = 4'h2; din = 8'h99;
    step();
    clr = 1'b0; we = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin
      re = 1'b1; raddr = 4'h2;
      we = 1'($urandom_range(0, 1)); waddr = 4'h2; din = 8'h99;
      step();
      n++;
    end
    re = 1'b0; we = 1'b0;
    check("clr_len_req", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      rd(a);
      if (a < 12) check("cleared_a", 32'(dout_a), 32'h00);
    end

    // Asynchronous reset in the middle of a clear restarts it from word 0.
    wr(1, 8'h5A);
    rd(1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("midclr_busy", 32'(busy_a), 32'd1);
    check("midclr_dout", 32'(dout_a), 32'h00);
    step();
    #2;
    rst = 1'b0;
    count_busy(n);
    check("clr_len_restart", 32'(n), 32'd16);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, 15));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 15));
      din   = DW'($urandom);
      clr   = ($urandom_range(0, 63) == 0);
      step();
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
